// File: rtl/pc_sequencer.sv
// Fetch/decode control FSM for the 16-bit program counter: drives the counter's
// IN/load/CE, keeps a small return-address stack, and gates instruction fetch.
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 16,
    parameter int unsigned      DEPTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_value,
    input  logic             mem_ready,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic             halt,
    input  logic             resume,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc_in,
    output logic             pc_load,
    output logic             pc_ce,
    output logic             fetch_req,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       sp
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  DEPTH_L = 4'(DEPTH);

    typedef enum logic [2:0] {
        S_VECTOR,
        S_FETCH,
        S_DECODE,
        S_HALT,
        S_FAULT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_stack [2**AW];
    logic [3:0]       r_sp;

    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_push_idx;
    logic [WIDTH-1:0] w_ret_addr;

    assign w_top_idx  = AW'(r_sp - 4'd1);
    assign w_push_idx = AW'(r_sp);
    assign w_ret_addr = pc_value + WIDTH'(1);
    // A full 8-entry stack reads back as 0 on the 3-bit occupancy port.
    assign sp         = r_sp[2:0];

    always_comb begin
        w_next    = r_state;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        pc_in     = pc_value;
        pc_load   = 1'b0;
        pc_ce     = 1'b0;
        fetch_req = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;

        case (r_state)
            S_VECTOR: begin
                pc_in   = RESET_VECTOR;
                pc_load = 1'b1;
                w_next  = S_FETCH;
            end
            S_FETCH: begin
                fetch_req = 1'b1;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                // Priority: halt > ret > call > jump > sequential.
                if (halt) begin
                    w_next = S_HALT;
                end else if (ret) begin
                    if (r_sp != '0) begin
                        pc_in   = r_stack[w_top_idx];
                        pc_load = 1'b1;
                        w_pop   = 1'b1;
                        w_next  = S_FETCH;
                    end else begin
                        w_next = S_FAULT;
                    end
                end else if (call) begin
                    if (r_sp < DEPTH_L) begin
                        pc_in   = target;
                        pc_load = 1'b1;
                        w_push  = 1'b1;
                        w_next  = S_FETCH;
                    end else begin
                        w_next = S_FAULT;
                    end
                end else if (jump) begin
                    pc_in   = target;
                    pc_load = 1'b1;
                    w_next  = S_FETCH;
                end else begin
                    pc_ce  = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) w_next = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                w_next = S_VECTOR;
            end
        endcase

        // Reset forces quiet outputs immediately, independent of the clock.
        if (reset) begin
            pc_in     = RESET_VECTOR;
            pc_load   = 1'b0;
            pc_ce     = 1'b0;
            fetch_req = 1'b0;
            halted    = 1'b0;
            fault     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_VECTOR;
            r_sp    <= '0;
        end else begin
            r_state <= w_next;
            if (w_push)
                r_sp <= r_sp + 4'd1;
            else if (w_pop)
                r_sp <= r_sp - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset)
            r_stack[w_push_idx] <= w_ret_addr;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a behavioural program counter, a vector table of
// decoded instructions, and a queue of expected post-instruction states.
module tb_pc_sequencer;

    localparam logic [15:0] RV = 16'h0010;
    localparam logic [3:0]  N  = 4'b0000;
    localparam logic [3:0]  J  = 4'b0001;
    localparam logic [3:0]  C  = 4'b0010;
    localparam logic [3:0]  R  = 4'b0100;
    localparam logic [3:0]  H  = 4'b1000;
    localparam logic [1:0]  OK = 2'b00;
    localparam logic [1:0]  HL = 2'b01;
    localparam logic [1:0]  FL = 2'b10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc_value = 16'h0000;
    logic        mem_ready = 1'b1;
    logic        jump = 1'b0, call = 1'b0, ret = 1'b0, halt = 1'b0, resume = 1'b0;
    logic [15:0] target = 16'h0000;
    logic [15:0] pc_in;
    logic        pc_load, pc_ce, fetch_req, halted, fault;
    logic [2:0]  sp;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned both_cnt = 0;

    typedef struct {
        int unsigned waits;
        logic [3:0]  ctl;
        logic [15:0] tgt;
        logic [15:0] pc;
        logic [2:0]  sp;
        logic [1:0]  st;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [2:0]  sp;
        logic [1:0]  st;
        string       tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    pc_sequencer #(
        .WIDTH(16),
        .DEPTH(4),
        .RESET_VECTOR(16'h0010)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pc_value(pc_value),
        .mem_ready(mem_ready),
        .jump(jump),
        .call(call),
        .ret(ret),
        .halt(halt),
        .resume(resume),
        .target(target),
        .pc_in(pc_in),
        .pc_load(pc_load),
        .pc_ce(pc_ce),
        .fetch_req(fetch_req),
        .halted(halted),
        .fault(fault),
        .sp(sp)
    );

    always #5 clk = ~clk;

    // Behavioural program_counter: load wins, else increment with wrap.
    always @(posedge clk) begin
        if (pc_load)
            pc_value <= pc_in;
        else if (pc_ce)
            pc_value <= pc_value + 16'd1;
    end

    always @(negedge clk) begin
        if (pc_load && pc_ce) both_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input int unsigned w, input logic [3:0] ctl,
                                input logic [15:0] tgt, input logic [15:0] pc,
                                input logic [2:0] s, input logic [1:0] st);
        vec_t v;
        v.waits = w;
        v.ctl   = ctl;
        v.tgt   = tgt;
        v.pc    = pc;
        v.sp    = s;
        v.st    = st;
        return v;
    endfunction

    task automatic clear_ctl();
        jump = 1'b0; call = 1'b0; ret = 1'b0; halt = 1'b0; resume = 1'b0;
        target = 16'h0000;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        mem_ready = 1'b1;
        clear_ctl();
        #1;
        chk({tag, "_load"},   32'(pc_load),   32'd0);
        chk({tag, "_ce"},     32'(pc_ce),     32'd0);
        chk({tag, "_fetch"},  32'(fetch_req), 32'd0);
        chk({tag, "_halted"}, 32'(halted),    32'd0);
        chk({tag, "_fault"},  32'(fault),     32'd0);
        chk({tag, "_pcin"},   32'(pc_in),     32'(RV));
        chk({tag, "_sp"},     32'(sp),        32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk({tag, "_vec_load"},  32'(pc_load),   32'd1);
        chk({tag, "_vec_pcin"},  32'(pc_in),     32'(RV));
        chk({tag, "_vec_fetch"}, 32'(fetch_req), 32'd0);
        tick();
        chk({tag, "_pc_rv"},     32'(pc_value),  32'(RV));
        chk({tag, "_fetch_up"},  32'(fetch_req), 32'd1);
        chk({tag, "_sp_after"},  32'(sp),        32'd0);
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        exp_t        e;
        logic [15:0] pc0;
        string       tag;
        v   = vecs[idx];
        tag = $sformatf("v%0d", idx);
        for (int i = 0; i < 20 && fetch_req !== 1'b1; i++) tick();
        chk({tag, "_in_fetch"}, 32'(fetch_req), 32'd1);
        if (fetch_req !== 1'b1) return;
        pc0 = pc_value;
        for (int unsigned i = 0; i < v.waits; i++) begin
            mem_ready = 1'b0;
            tick();
            chk($sformatf("%s_wait%0d_req", tag, i), 32'(fetch_req), 32'd1);
            chk($sformatf("%s_wait%0d_pc", tag, i),  32'(pc_value),  32'(pc0));
        end
        mem_ready = 1'b1;
        tick();
        chk({tag, "_dec_req"}, 32'(fetch_req), 32'd0);
        chk({tag, "_dec_pc"},  32'(pc_value),  32'(pc0));
        jump   = v.ctl[0];
        call   = v.ctl[1];
        ret    = v.ctl[2];
        halt   = v.ctl[3];
        target = v.tgt;
        e.pc  = v.pc;
        e.sp  = v.sp;
        e.st  = v.st;
        e.tag = tag;
        sb.push_back(e);
        tick();
        clear_ctl();
        e = sb.pop_front();
        chk({e.tag, "_pc"},     32'(pc_value), 32'(e.pc));
        chk({e.tag, "_sp"},     32'(sp),       32'(e.sp));
        chk({e.tag, "_halted"}, 32'(halted),   32'(e.st[0]));
        chk({e.tag, "_fault"},  32'(fault),    32'(e.st[1]));
        if (e.st == OK)
            chk({e.tag, "_next_req"}, 32'(fetch_req), 32'd1);
    endtask

    initial begin
        vecs.push_back(mk(0, N, 16'h0000, 16'h0011, 3'd0, OK)); // 0
        vecs.push_back(mk(0, N, 16'h0000, 16'h0012, 3'd0, OK)); // 1
        vecs.push_back(mk(0, J, 16'h0040, 16'h0040, 3'd0, OK)); // 2
        vecs.push_back(mk(0, C, 16'h0100, 16'h0100, 3'd1, OK)); // 3
        vecs.push_back(mk(0, C, 16'h0200, 16'h0200, 3'd2, OK)); // 4
        vecs.push_back(mk(0, R, 16'h0000, 16'h0101, 3'd1, OK)); // 5
        vecs.push_back(mk(0, R, 16'h0000, 16'h0041, 3'd0, OK)); // 6
        vecs.push_back(mk(3, N, 16'h0000, 16'h0042, 3'd0, OK)); // 7
        vecs.push_back(mk(0, J, 16'hFFFF, 16'hFFFF, 3'd0, OK)); // 8
        vecs.push_back(mk(0, N, 16'h0000, 16'h0000, 3'd0, OK)); // 9
        vecs.push_back(mk(0, J, 16'hFFFF, 16'hFFFF, 3'd0, OK)); // 10
        vecs.push_back(mk(0, C, 16'h0300, 16'h0300, 3'd1, OK)); // 11
        vecs.push_back(mk(0, R, 16'h0000, 16'h0000, 3'd0, OK)); // 12
        vecs.push_back(mk(0, C, 16'h1000, 16'h1000, 3'd1, OK)); // 13
        vecs.push_back(mk(0, C, 16'h2000, 16'h2000, 3'd2, OK)); // 14
        vecs.push_back(mk(0, C, 16'h3000, 16'h3000, 3'd3, OK)); // 15
        vecs.push_back(mk(0, C, 16'h4000, 16'h4000, 3'd4, OK)); // 16
        vecs.push_back(mk(0, C, 16'h5000, 16'h4000, 3'd4, FL)); // 17 overflow
        vecs.push_back(mk(0, R, 16'h0000, 16'h0010, 3'd0, FL)); // 18 underflow
        vecs.push_back(mk(0, C, 16'h0500, 16'h0500, 3'd1, OK)); // 19
        vecs.push_back(mk(0, H | C, 16'h0600, 16'h0500, 3'd1, HL)); // 20
        vecs.push_back(mk(0, N, 16'h0000, 16'h0501, 3'd1, OK)); // 21
        vecs.push_back(mk(0, C, 16'h0700, 16'h0700, 3'd2, OK)); // 22

        #2;
        do_reset("rst0");
        for (int i = 0; i <= 17; i++) run_vec(i);

        // FAULT ignores controls and resume until reset.
        resume = 1'b1;
        call   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("fault_hold%0d_flag", i),  32'(fault),     32'd1);
            chk($sformatf("fault_hold%0d_pc", i),    32'(pc_value),  32'h4000);
            chk($sformatf("fault_hold%0d_sp", i),    32'(sp),        32'd4);
            chk($sformatf("fault_hold%0d_fetch", i), 32'(fetch_req), 32'd0);
        end
        do_reset("rst1");

        run_vec(18);
        do_reset("rst2");

        run_vec(19);
        run_vec(20);
        // HALT ignores decode controls; resume exits without advancing the PC.
        jump = 1'b1;
        call = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("halt_hold%0d_flag", i),  32'(halted),    32'd1);
            chk($sformatf("halt_hold%0d_fetch", i), 32'(fetch_req), 32'd0);
            chk($sformatf("halt_hold%0d_pc", i),    32'(pc_value),  32'h0500);
            chk($sformatf("halt_hold%0d_sp", i),    32'(sp),        32'd1);
        end
        clear_ctl();
        resume = 1'b1;
        #1;
        chk("resume_load", 32'(pc_load), 32'd0);
        chk("resume_ce",   32'(pc_ce),   32'd0);
        tick();
        resume = 1'b0;
        chk("resume_halted", 32'(halted),    32'd0);
        chk("resume_fetch",  32'(fetch_req), 32'd1);
        chk("resume_pc",     32'(pc_value),  32'h0500);

        run_vec(21);
        run_vec(22);

        // Reset mid-FETCH with a non-empty stack.
        chk("midfetch_pre_req", 32'(fetch_req), 32'd1);
        mem_ready = 1'b0;
        #2;
        do_reset("rst_mid");

        chk("load_ce_exclusive", both_cnt, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control FSM that sequences the 16-bit `program_counter` through the processor's fetch/decode loop. It drives the counter's IN, load and CE inputs, handles sequential advance, jump, call and return, and holds return addresses in a small hardware stack. It also gates the instruction-memory fetch request, and provides halt/resume and a sticky fault state for stack errors.

## Interface
- `WIDTH`, 16: address width; must match `program_counter`.
- `DEPTH`, 4: return-stack entries, 1..8.
- `RESET_VECTOR`, 16'h0000: address loaded into the PC after reset.

- `clk`  in  1: rising-edge clock, shared with `program_counter`.
- `reset`  in  1: asynchronous, active-high reset.
- `pc_value`  in  WIDTH: current PC (the counter's OUT).
- `mem_ready`  in  1: instruction word available this cycle.
- `jump`  in  1: decoded unconditional/taken branch, sampled in DECODE.
- `call`  in  1: decoded call, sampled in DECODE.
- `ret`  in  1: decoded return, sampled in DECODE.
- `halt`  in  1: decoded halt, sampled in DECODE.
- `resume`  in  1: leave HALT.
- `target`  in  WIDTH: jump/call destination, sampled in DECODE.
- `pc_in`  out  WIDTH: to counter IN.
- `pc_load`  out  1: to counter load.
- `pc_ce`  out  1: to counter CE.
- `fetch_req`  out  1: instruction-memory read request.
- `halted`  out  1: high in HALT.
- `fault`  out  1: high in FAULT.
- `sp`  out  3: return-stack occupancy, 0..DEPTH.

## Operation
- Counter contract: on a rising edge, `pc_load`=1 loads `pc_in`. Otherwise `pc_ce`=1 increments the counter, wrapping 16'hFFFF->16'h0000. The sequencer never asserts `pc_load` and `pc_ce` together.
- States: VECTOR, FETCH, DECODE, HALT, FAULT. State, stack and `sp` are registered. Outputs are decoded combinationally from the state and the sampled inputs.
- VECTOR: `pc_load`=1, `pc_in`=RESET_VECTOR. Next state is FETCH.
- FETCH: `fetch_req`=1. Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1. No PC change.
- DECODE: one cycle. Priority is halt > ret > call > jump > sequential.
  - halt: no PC change. Next state is HALT.
  - ret with `sp`>0: `pc_in`=top entry, `pc_load`=1, pop. Next state is FETCH.
  - ret with `sp`=0: underflow. No PC change, no pop. Next state is FAULT.
  - call with `sp`<DEPTH: push `pc_value`+1 (mod 2^16), `pc_in`=`target`, `pc_load`=1. Next state is FETCH.
  - call with `sp`=DEPTH: overflow. No push, no PC change. Next state is FAULT.
  - jump: `pc_in`=`target`, `pc_load`=1. Next state is FETCH.
  - none asserted: `pc_ce`=1. Next state is FETCH.
- HALT: `halted`=1, PC frozen, no fetch. `resume`=1 -> FETCH; the PC is not advanced on exit.
- FAULT: `fault`=1, PC frozen, no fetch. Only `reset` exits this state.
- In every non-DECODE, non-VECTOR state, `pc_in`=`pc_value` and `pc_load`=`pc_ce`=0.

## Timing
- Reset (asynchronous, any state, including mid-fetch or mid-DECODE):
  - state returns to VECTOR, `sp`=0, stack contents are don't-care.
  - while `reset`=1: `pc_load`=0, `pc_ce`=0, `fetch_req`=0, `halted`=0, `fault`=0, `pc_in`=RESET_VECTOR.
- First edge after reset release: the PC loads RESET_VECTOR. `fetch_req` rises in the following cycle.
- Instruction period: one cycle per FETCH wait cycle, plus one FETCH cycle with `mem_ready`, plus one DECODE cycle. With zero-wait memory this is 2 cycles per instruction.
- The new PC is visible on `pc_value` in the first FETCH cycle after DECODE.
- The stack push/pop and the PC load/increment take effect on the same edge that leaves DECODE.
- Control inputs are ignored outside DECODE (VECTOR, FETCH, HALT, FAULT). `resume` is honoured only in HALT.
- `mem_ready` is ignored outside FETCH.

## Test plan
- Reset with RESET_VECTOR=16'h0010, `mem_ready` tied to 1, no controls -> `pc_value` runs 0x0010, 0x0011, 0x0012, each value held for 2 cycles; `fetch_req` is high every other cycle.
- At PC 0x0012, assert `jump` with `target`=0x0040 in DECODE -> next FETCH shows 0x0040; `sp` stays 0.
- At 0x0040, `call` to 0x0100; at 0x0100, `call` to 0x0200 -> `sp`=2. Then `ret` -> PC 0x0101, `sp`=1; `ret` -> PC 0x0041, `sp`=0.
- DEPTH=4: five nested calls -> the fifth enters FAULT, `fault`=1, PC unchanged, `sp`=4. A later `reset` clears `fault` and `sp`, and the PC reloads RESET_VECTOR.
- `ret` with `sp`=0 -> FAULT, no PC change. Separately, `halt`+`call` asserted together -> HALT with no push. Holding `mem_ready`=0 for 3 cycles -> FETCH held for those 3 cycles with the PC frozen.
- PC at 0xFFFF sequential -> 0x0000. A `call` from 0xFFFF pushes 0x0000, and a later `ret` returns to 0x0000. Asserting `reset` mid-FETCH -> outputs take their reset values immediately, without waiting for a clock edge.
